// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Op class is S[3:2] of the ALU opcode.
  localparam logic [1:0] OPC_ARITH = 2'b00;
  localparam logic [1:0] OPC_LOGIC = 2'b01;
  localparam logic [1:0] OPC_SHR   = 2'b10;
  localparam logic [1:0] OPC_SHL   = 2'b11;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer FSM: state register, shift counter and READY/BUSY/DONE flags.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_shift,
  input  logic [SHAMT_W-1:0] op_shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               last_shift,
  output state_t             state
);

  logic [SHAMT_W-1:0] cnt_q;

  assign last_shift = (state == ST_SHIFT) && (cnt_q == SHAMT_W'(1));

  // Handshake: a command is taken on any rising edge where start=1 and ready=1;
  // start is ignored whenever ready=0, nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt_q <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (!op_shift) begin
              state <= ST_EXEC;
              busy  <= 1'b1;
            end else if (op_shamt == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_SHIFT;
              cnt_q <= op_shamt;
              busy  <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer in front of the combinational ALU; builds
// multi-bit shifts by looping ALU_F back into ALU_A one bit per cycle.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  input  logic [3:0]         op_s,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               op_cin,
  input  logic               op_fill,
  input  logic [SHAMT_W-1:0] op_shamt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic               alu_dl,
  output logic               alu_dr,
  output logic [3:0]         alu_s,
  input  logic [WIDTH-1:0]   alu_f,
  input  logic               alu_cout,
  output logic [WIDTH-1:0]   result,
  output logic               res_cout,
  output logic               zero,
  output logic               neg,
  output logic               done,
  output state_t             dbg_state
);

  logic             accept, last_shift, shift_out, fill_q;
  logic             res_load, cout_next;
  logic [WIDTH-1:0] res_next;

  alu_seq_ctrl #(.SHAMT_W(SHAMT_W)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_shift   (op_s[3]),
    .op_shamt   (op_shamt),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .last_shift (last_shift),
    .state      (dbg_state)
  );

  assign accept = ready & start;
  assign alu_dl = fill_q;
  assign alu_dr = fill_q;
  // The bit that falls off the end this step; the ALU does not report it.
  assign shift_out = alu_s[2] ? alu_a[WIDTH-1] : alu_a[0];

  always_comb begin
    res_load  = 1'b0;
    res_next  = alu_f;
    cout_next = 1'b0;
    if (accept && op_s[3] && (op_shamt == '0)) begin
      res_load = 1'b1;
      res_next = op_a;
    end else if (dbg_state == ST_EXEC) begin
      res_load  = 1'b1;
      cout_next = (alu_s[3:2] == OPC_ARITH) & alu_cout;
    end else if (last_shift) begin
      res_load  = 1'b1;
      cout_next = shift_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      fill_q   <= 1'b0;
      alu_s    <= '0;
      result   <= '0;
      res_cout <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_cin <= op_cin;
        fill_q  <= op_fill;
        alu_s   <= op_s;
      end else if (dbg_state == ST_SHIFT) begin
        alu_a <= alu_f;
      end
      if (res_load) begin
        result   <= res_next;
        res_cout <= cout_next;
        zero     <= (res_next == '0);
        neg      <= res_next[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the ALU.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk, rst, start, ready, busy, done;
  logic [3:0]    op_s, alu_s;
  logic [W-1:0]  op_a, op_b, alu_a, alu_b, alu_f, result;
  logic          op_cin, op_fill, alu_cin, alu_dl, alu_dr, alu_cout;
  logic [SW-1:0] op_shamt;
  logic          res_cout, zero, neg;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]    s;
    logic [W-1:0]  a, b;
    logic          cin, fill;
    logic [SW-1:0] shamt;
    logic [W-1:0]  exp_res;
    logic          exp_cout, exp_zero, exp_neg;
    int            exp_lat;
  } vec_t;

  vec_t vecs[11];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  logic [W-1:0] opnd;
  logic [W:0]   sum;
  always_comb begin
    opnd     = '0;
    sum      = '0;
    alu_f    = '0;
    alu_cout = 1'b1; // carry is meaningless outside arith; 1 exposes leakage
    case (alu_s[3:2])
      2'b00: begin
        case (alu_s[1:0])
          2'b00:   opnd = '0;
          2'b01:   opnd = alu_b;
          2'b10:   opnd = ~alu_b;
          default: opnd = '1;
        endcase
        sum      = {1'b0, alu_a} + {1'b0, opnd} + (W+1)'(alu_cin);
        alu_f    = sum[W-1:0];
        alu_cout = sum[W];
      end
      2'b01: begin
        case (alu_s[1:0])
          2'b00:   alu_f = alu_a & alu_b;
          2'b01:   alu_f = alu_a | alu_b;
          2'b10:   alu_f = alu_a ^ alu_b;
          default: alu_f = ~alu_a;
        endcase
      end
      2'b10:   alu_f = {alu_dl, alu_a[W-1:1]};
      default: alu_f = {alu_a[W-2:0], alu_dr};
    endcase
  end

  alu_op_sequencer #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy),
    .op_s(op_s), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_fill(op_fill), .op_shamt(op_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_dl(alu_dl),
    .alu_dr(alu_dr), .alu_s(alu_s), .alu_f(alu_f), .alu_cout(alu_cout),
    .result(result), .res_cout(res_cout), .zero(zero), .neg(neg),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op_s = v.s; op_a = v.a; op_b = v.b; op_cin = v.cin;
    op_fill = v.fill; op_shamt = v.shamt;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int lat;
    logic [W-1:0] exp_r;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v.exp_res);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_alu_s"}, W'(alu_s), W'(v.s));
    check({tag, "_alu_b"}, alu_b, v.b);
    lat = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, W'(done), W'(1));
    if (!done) begin
      void'(exp_q.pop_front());
      return;
    end
    exp_r = exp_q.pop_front();
    check({tag, "_latency"}, W'(lat), W'(v.exp_lat));
    check({tag, "_result"}, result, exp_r);
    check({tag, "_cout"}, W'(res_cout), W'(v.exp_cout));
    check({tag, "_zero"}, W'(zero), W'(v.exp_zero));
    check({tag, "_neg"}, W'(neg), W'(v.exp_neg));
    @(posedge clk);
    #1 check({tag, "_ready_after"}, W'(ready), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    int e, n_done, first_e, second_e;
    logic [W-1:0] first_res, second_res;
    logic busy_ready_bad;

    //        s        a             b             cin  fill shamt  result        cout zero neg lat
    vecs[0]  = '{4'b0001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'b0010, 32'h00000005, 32'h00000003, 1'b1, 1'b0, 5'd0,  32'h00000002, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'b0110, 32'h0000F0F0, 32'h0000FFFF, 1'b0, 1'b0, 5'd0,  32'h00000F0F, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'b0001, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[4]  = '{4'b0100, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0, 5'd0,  32'h80000001, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{4'b1100, 32'h10000001, 32'h00000000, 1'b0, 1'b0, 5'd4,  32'h00000010, 1'b1, 1'b0, 1'b0, 4};
    vecs[6]  = '{4'b1000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 31};
    vecs[7]  = '{4'b1000, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{4'b1000, 32'h80000001, 32'h00000000, 1'b0, 1'b0, 5'd1,  32'h40000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b1100, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 5'd1,  32'h00000001, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{4'b0011, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1};

    rst = 1'b1; start = 1'b0;
    op_s = '0; op_a = '0; op_b = '0; op_cin = 1'b0; op_fill = 1'b0; op_shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", W'(ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    check("rst_zero", W'(zero), W'(0));
    check("rst_alu_a", alu_a, '0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // START held high through a 10-step shift: only one DONE for the shift,
    // then the (still asserted) add is taken once READY returns.
    v = '{4'b1100, 32'h00000001, 32'h0, 1'b0, 1'b0, 5'd10, 32'h00000400, 1'b0, 1'b0, 1'b0, 10};
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    op_s = 4'b0001; op_a = 32'd7; op_b = 32'd8; op_cin = 1'b0; op_shamt = '0;
    n_done = 0; first_e = -1; second_e = -1; first_res = '0; second_res = '0;
    busy_ready_bad = 1'b0;
    for (e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1 if (e == 12) start = 1'b0;
      @(negedge clk);
      if (e < 10 && (ready || !busy)) busy_ready_bad = 1'b1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin first_e = e; first_res = result; end
        if (n_done == 2) begin second_e = e; second_res = result; end
      end
    end
    check("busy_ready_during_shift", W'(busy_ready_bad), W'(0));
    check("busy_done_count", W'(n_done), W'(2));
    check("busy_first_done_edge", W'(first_e), W'(10));
    check("busy_first_result", first_res, 32'h00000400);
    check("busy_second_done_edge", W'(second_e), W'(13));
    check("busy_second_result", second_res, 32'd15);

    // Reset three cycles into a 20-step shift aborts without DONE.
    v = '{4'b1100, 32'h00000005, 32'h0, 1'b0, 1'b0, 5'd20, 32'h0, 1'b0, 1'b0, 1'b0, 20};
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", W'(ready), W'(1));
    check("abort_busy", W'(busy), W'(0));
    check("abort_result", result, '0);
    check("abort_alu_a", alu_a, '0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", W'(n_done), W'(0));
    v = '{4'b0001, 32'd2, 32'd3, 1'b0, 1'b0, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1};
    run_cmd(v, "post_abort_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle command sequencer that sits directly upstream of the team's 32-bit combinational ALU. It accepts one operation per handshake, drives the ALU's A/B/CIN/DL/DR/S inputs from registers, and captures F/COUT into a registered result with flags. For shift ops it iterates the ALU's single-bit shift SHAMT times, feeding F back into A, to form multi-bit shifts. It also produces the shifted-out bit as carry, which the ALU does not.

## Interface
- WIDTH, 32: datapath width; must match the ALU.
- SHAMT_W, 5: shift-amount width; max shift is 2^SHAMT_W-1.

- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  command strobe; sampled only when READY=1
- READY  out  1  high in IDLE only
- BUSY  out  1  high in EXEC or SHIFT
- OP_S  in  4  ALU opcode: S[3:2] 00 arith, 01 logic, 10 shift right, 11 shift left
- OP_A, OP_B  in  WIDTH  operands
- OP_CIN  in  1  carry-in (arith only)
- OP_FILL  in  1  fill bit for shifts; drives both ALU_DL and ALU_DR
- OP_SHAMT  in  SHAMT_W  shift count (shift ops only)
- ALU_A, ALU_B  out  WIDTH  to ALU
- ALU_CIN, ALU_DL, ALU_DR  out  1  to ALU
- ALU_S  out  4  to ALU
- ALU_F  in  WIDTH  from ALU
- ALU_COUT  in  1  from ALU
- RESULT  out  WIDTH  last completed result
- RES_COUT  out  1  carry of last result
- ZERO, NEG  out  1  RESULT==0, RESULT[WIDTH-1]
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, EXEC, SHIFT, DONE. Reset: state IDLE; every output and internal register 0 except READY=1.
- IDLE with START=1 at edge k:
  - Latch OP_* into command registers, which drive ALU_* directly.
  - Arith/logic: go to EXEC.
  - Shift with SHAMT>0: go to SHIFT, cnt=SHAMT.
  - Shift with SHAMT=0: RESULT=OP_A, RES_COUT=0, go directly to DONE.
- EXEC (one cycle):
  - Capture RESULT=ALU_F.
  - RES_COUT = ALU_COUT for arith, 0 for logic.
  - Go to DONE.
- SHIFT, each cycle:
  - ALU_A=ALU_F, cnt=cnt-1.
  - Shifted-out bit (ALU_A[0] for right, ALU_A[WIDTH-1] for left, before the update) goes into a carry register.
  - When cnt==1 at the edge: RESULT=ALU_F, RES_COUT=that bit, go to DONE.
- DONE (one cycle): DONE=1, then IDLE.
- START when READY=0 is ignored; no queueing.
- RESULT, RES_COUT, ZERO and NEG update only on completion and hold until the next completion. ZERO and NEG are registered with RESULT.
- RST asserted mid-operation aborts immediately to reset values. No DONE is produced for the aborted command.

## Timing
- Arith/logic: START edge k; RESULT valid and DONE=1 in the cycle after edge k+1. READY again after edge k+2.
- Shift by N≥1: RESULT and DONE after edge k+N. Shift by 0: after edge k.
- Maximum throughput: one arith/logic command per 3 cycles.
- ALU is combinational; the ALU_F→ALU_A loop through the ALU is a single-cycle path.

## Structure
- Package alu_seq_pkg holds:
  - state enum (IDLE/EXEC/SHIFT/DONE)
  - op-class constants OPC_ARITH=2'b00, OPC_LOGIC=2'b01, OPC_SHR=2'b10, OPC_SHL=2'b11
  - WIDTH and SHAMT_W defaults
- Sub-module alu_seq_ctrl contains the state register, shift counter and DONE/READY/BUSY decode.
- The top holds the operand and result registers.
- The ALU itself is instantiated outside, at the next level up.

## Test plan
- Add overflow: S=0001, A=0xFFFFFFFF, B=1, CIN=0 -> RESULT=0, RES_COUT=1, ZERO=1, DONE in the cycle after edge k+1.
- Subtract: S=0010, A=5, B=3, CIN=1 -> RESULT=2, RES_COUT=1, NEG=0. Logic S=0110 A=0xF0F0 B=0xFFFF -> 0x0F0F, RES_COUT=0.
- Shift left: S=1100, A=0x10000001, SHAMT=4, FILL=0 -> RESULT=0x00000010, RES_COUT=1, DONE after edge k+4.
- Shift right: S=1000, A=0, SHAMT=31, FILL=1 -> RESULT=0xFFFFFFFE, RES_COUT=0, NEG=1, DONE after edge k+31. SHAMT=0 returns A after edge k.
- START pulsed while BUSY during a SHAMT=10 shift -> ignored; exactly one DONE; second command accepted only once READY=1.
- RST pulsed 3 cycles into a SHAMT=20 shift -> READY=1, RESULT=0, no DONE; the following add completes normally.
